// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and received-byte outputs of the UART receiver.
interface uart_rx_if #(
  parameter int DATA_WD     = 8,
  parameter int PRESCALE_WD = 6
);
  logic                   RX_IN;
  logic [PRESCALE_WD-1:0] prescale;
  logic                   parity_enable;
  logic                   parity_type;
  logic [DATA_WD-1:0]     P_DATA;
  logic                   data_valid;
  logic                   parity_error;
  logic                   stop_error;
  logic                   rx_busy;

  modport master (
    output RX_IN, prescale, parity_enable, parity_type,
    input  P_DATA, data_valid, parity_error, stop_error, rx_busy
  );

  modport slave (
    input  RX_IN, prescale, parity_enable, parity_type,
    output P_DATA, data_valid, parity_error, stop_error, rx_busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start detect, 3-sample majority per bit, LSB-first shift,
// optional parity and stop checking, registered one-cycle result pulses.
//
// state  | meaning
// IDLE   | waiting for a falling edge on RX_IN
// START  | validating the start bit (1 = glitch, back to IDLE)
// DATA   | shifting in DATA_WD data bits
// PARITY | comparing the parity bit against the received data
// STOP   | sampling the stop bit, results registered on its last edge
module uart_rx_core #(
  parameter int DATA_WD     = 8,
  parameter int PRESCALE_WD = 6
) (
  input logic     CLK,
  input logic     RST,
  uart_rx_if.slave rx
);
  localparam int BIT_CW = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_prev_q, rx_prev_d;
  logic                   armed_q, armed_d;
  logic [PRESCALE_WD-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_WD-1:0] p_q, p_d;
  logic                   par_en_q, par_en_d;
  logic                   par_type_q, par_type_d;
  logic                   par_err_q, par_err_d;
  logic [2:0]             smp_q, smp_d;
  logic [DATA_WD-1:0]     shift_q, shift_d;
  logic [DATA_WD-1:0]     p_data_q, p_data_d;
  logic                   dv_q, dv_d;
  logic                   pe_q, pe_d;
  logic                   se_q, se_d;

  logic                   p_last;
  logic                   bit_val;
  logic                   exp_par;
  logic [PRESCALE_WD-1:0] half;
  logic [PRESCALE_WD-1:0] p_sel;

  always_comb begin
    if (rx.prescale == PRESCALE_WD'(8) || rx.prescale == PRESCALE_WD'(16) ||
        rx.prescale == PRESCALE_WD'(32))
      p_sel = rx.prescale;
    else
      p_sel = PRESCALE_WD'(8);
  end

  assign half    = p_q >> 1;
  assign p_last  = (edge_cnt_q == p_q - 1'b1);
  assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  assign exp_par = par_type_q ? ~^shift_q : ^shift_q;

  always_comb begin
    state_d    = state_q;
    rx_prev_d  = rx.RX_IN;
    // A start is only accepted once the line has been seen high since reset.
    armed_d    = armed_q | rx.RX_IN;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    p_d        = p_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    par_err_d  = par_err_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = p_last ? '0 : edge_cnt_q + 1'b1;
      if (edge_cnt_q == half - 1'b1) smp_d[0] = rx.RX_IN;
      if (edge_cnt_q == half)        smp_d[1] = rx.RX_IN;
      if (edge_cnt_q == half + 1'b1) smp_d[2] = rx.RX_IN;
    end

    case (state_q)
      IDLE: begin
        if (armed_q && rx_prev_q && !rx.RX_IN) begin
          // Detect cycle is edge 0 of the start bit.
          state_d    = START;
          edge_cnt_d = PRESCALE_WD'(1);
          bit_cnt_d  = '0;
          p_d        = p_sel;
          par_en_d   = rx.parity_enable;
          par_type_d = rx.parity_type;
          par_err_d  = 1'b0;
        end
      end
      START: begin
        if (p_last) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (p_last) begin
          shift_d = {bit_val, shift_q[DATA_WD-1:1]};
          if (bit_cnt_q == BIT_CW'(DATA_WD - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (p_last) begin
          par_err_d = (bit_val != exp_par);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (p_last) begin
          state_d = IDLE;
          se_d    = ~bit_val;
          pe_d    = par_err_q;
          if (bit_val && !par_err_q) begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      rx_prev_q  <= 1'b1;
      armed_q    <= 1'b0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      p_q        <= PRESCALE_WD'(8);
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_err_q  <= 1'b0;
      smp_q      <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_prev_q  <= rx_prev_d;
      armed_q    <= armed_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      p_q        <= p_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      par_err_q  <= par_err_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign rx.P_DATA       = p_data_q;
  assign rx.data_valid   = dv_q;
  assign rx.parity_error = pe_q;
  assign rx.stop_error   = se_q;
  assign rx.rx_busy      = (state_q != IDLE);
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver: the downstream counterpart of the UART_TX block. It consumes the serial stream that UART_TX drives on TX_OUT and rebuilds the parallel byte.
- Oversamples RX_IN by a runtime prescale, majority-votes three mid-bit samples, and shifts data in LSB first.
- Checks the optional even/odd parity bit and the stop bit, then presents P_DATA with a one-cycle data_valid pulse.
- Frame format is the same as UART_TX: start(0), DATA_WD data bits LSB first, optional parity, stop(1).

Parameters:
- DATA_WD, 8, data bits per frame.
- PRESCALE_WD, 6, width of the prescale input.

Ports:
- CLK  input  1  oversampling clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; already synchronous to CLK; idles high.
- prescale  input  PRESCALE_WD  CLK cycles per bit; legal values 8, 16, 32.
- parity_enable  input  1  1 = frame carries a parity bit.
- parity_type  input  1  0 = even, 1 = odd.
- P_DATA  output  DATA_WD  last correctly received byte.
- data_valid  output  1  one-cycle pulse when P_DATA is updated.
- parity_error  output  1  one-cycle pulse on parity mismatch.
- stop_error  output  1  one-cycle pulse when the stop bit is sampled as 0.
- rx_busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (asynchronous, RST=0): all outputs 0, FSM to IDLE, counters 0, rx_prev=1. Any partial frame is discarded.
- Any prescale value other than 8, 16 or 32 is treated as 8.
- Falling-edge detect: start is recognised in IDLE only when RX_IN==0 and rx_prev==1, where rx_prev is RX_IN registered.
  - After a mid-frame reset the block waits for the line to go high before accepting a start.
- The start-detect cycle is edge 0 of the start bit.
- At start detect, prescale, parity_enable and parity_type are latched. Changes to these inputs during a frame are ignored.
- edge_cnt counts 0..P-1 within each bit, where P is the latched prescale.
- Bit sampling: RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three, decided at edge_cnt == P-1.
- FSM (each state advances at edge_cnt==P-1):
  - IDLE: waits for a falling edge, then goes to START.
  - START: bit==1 is a glitch: return to IDLE, no error flagged. Otherwise go to DATA.
  - DATA: shift register fills LSB first; bit_cnt counts 0..DATA_WD-1. After the last bit go to PARITY if parity is enabled, else to STOP.
  - PARITY: expected bit = ^data (even) or ~^data (odd). A mismatch sets the internal par_err flag. Go to STOP.
  - STOP: at edge P-1, go to IDLE.
- Frame completion, all outputs registered in the cycle after STOP edge P-1:
  - stop bit 1 and no par_err: P_DATA <= shift register, data_valid=1.
  - stop bit 0: stop_error=1; data_valid=0; P_DATA unchanged.
  - par_err: parity_error=1; data_valid=0; P_DATA unchanged.
  - Both errors may assert in the same cycle.
- Latency: with start detect at cycle t0 and N bits per frame (10, or 11 with parity), data_valid is high exactly at cycle t0+N*P.
- Back-to-back frames: the FSM enters IDLE with rx_prev=1 from the stop bit. A start bit beginning immediately after the stop bit is detected in that IDLE cycle, and no frame is lost.
- data_valid, parity_error and stop_error are each high for at most one cycle per frame and are 0 otherwise.
- rx_busy is 1 from the cycle after start detect until the FSM returns to IDLE.
- P_DATA holds its value between frames.

Test Plan:
- prescale=8, parity off, drive frame 0xA3 -> one data_valid pulse at t0+80; P_DATA=0xA3; no error pulses.
- prescale=16, even parity, frame 0xB4 with parity bit 0 -> data_valid at t0+176; P_DATA=0xB4. Repeat with parity bit 1 -> parity_error pulse; no data_valid; P_DATA stays 0xB4.
- prescale=32, odd parity, frame 0xD2 with parity bit 1 -> P_DATA=0xD2. Repeat with stop bit 0 -> stop_error pulse; no data_valid.
- Start glitch: RX_IN low for 2 cycles at prescale=8 -> FSM returns to IDLE at edge 7; no output pulses. A following valid 0x5A frame is received correctly.
- Back-to-back: 0x11, 0x22 and 0x33 sent with no idle gap at prescale=16 -> three data_valid pulses exactly 160 cycles apart, carrying the correct bytes in order.
- Reset mid-frame: assert RST during DATA of 0x77, release while the line is still in the frame -> outputs 0 immediately; no spurious frame. The next 0x3C frame after line idle is received correctly.
